// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's ROM, redirect/stall and IF/ID signals.
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc2;
    logic        fault;
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_bubble_cnt;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, id_valid, id_instr, id_pc, id_pc2, fault,
               perf_fetch_cnt, perf_bubble_cnt
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, id_valid, id_instr, id_pc, id_pc2, fault,
               perf_fetch_cnt, perf_bubble_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register for the 16-bit pipelined RISC core.
// Define FETCH_PERF_CNT_EN to build the fetch/bubble performance counters.
module fetch_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] id_instr_q, id_pc_q, id_pc2_q;
    logic        fault_q;

    logic        load_redirect;
    logic        set_fault;
    logic        capture;
    logic        squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (bus.redirect_valid && bus.redirect_pc[0]) state_d = FAULT;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Redirect outranks stall; a misaligned target squashes and parks in FAULT.
    always_comb begin
        load_redirect = 1'b0;
        set_fault     = 1'b0;
        capture       = 1'b0;
        if (state_q == RUN) begin
            load_redirect = bus.redirect_valid && !bus.redirect_pc[0];
            set_fault     = bus.redirect_valid &&  bus.redirect_pc[0];
            capture       = !bus.redirect_valid && !bus.stall;
        end
        squash = load_redirect || set_fault;
    end

    always_comb begin
        pc_d = pc_q;
        if (load_redirect) begin
            pc_d = bus.redirect_pc;
        end else if (capture) begin
            pc_d = pc_q + PC_STEP;
        end
        id_valid_d = id_valid_q;
        if (squash) begin
            id_valid_d = 1'b0;
        end else if (capture) begin
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= PC_RESET;
            id_valid_q <= 1'b0;
            id_instr_q <= 16'h0000;
            id_pc_q    <= 16'h0000;
            id_pc2_q   <= 16'h0000;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            if (capture) begin
                id_instr_q <= bus.imem_rdata;
                id_pc_q    <= pc_q;
                id_pc2_q   <= pc_q + 16'd2;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_q, perf_bubble_q;
    logic        bubble_evt;

    // Start-up edge (IDLE->RUN) counts as a bubble; the FAULT entry edge does not.
    assign bubble_evt = (state_d == RUN) && !id_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= 16'h0000;
            perf_bubble_q <= 16'h0000;
        end else begin
            if (capture && perf_fetch_q != 16'hFFFF) begin
                perf_fetch_q <= perf_fetch_q + 16'd1;
            end
            if (bubble_evt && perf_bubble_q != 16'hFFFF) begin
                perf_bubble_q <= perf_bubble_q + 16'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt  = perf_fetch_q;
    assign bus.perf_bubble_cnt = perf_bubble_q;
`else
    assign bus.perf_fetch_cnt  = 16'h0000;
    assign bus.perf_bubble_cnt = 16'h0000;
`endif

    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_pc2    = id_pc2_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: start-up, stall, redirect, fault, wrap, perf.
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_stage_if bus_if ();

    fetch_stage #(
        .PC_RESET (16'h0000),
        .PC_STEP  (16'd2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word 0 = 2A51, word i (i>0) = C000 | i.
    always_comb begin
        if (bus_if.imem_addr[4:1] == 4'd0) begin
            bus_if.imem_rdata = 16'h2A51;
        end else begin
            bus_if.imem_rdata = {12'hC00, bus_if.imem_addr[4:1]};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [15:0] instr,
                          input logic [15:0] pc, input logic [15:0] addr);
        chk({tag, ".valid"}, {15'd0, bus_if.id_valid}, {15'd0, v});
        chk({tag, ".instr"}, bus_if.id_instr, instr);
        chk({tag, ".pc"},    bus_if.id_pc, pc);
        chk({tag, ".pc2"},   bus_if.id_pc2, pc + 16'd2);
        chk({tag, ".addr"},  bus_if.imem_addr, addr);
    endtask

    task automatic chk_perf(input string tag, input logic [15:0] f, input logic [15:0] b);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".fetch"},  bus_if.perf_fetch_cnt, f);
        chk({tag, ".bubble"}, bus_if.perf_bubble_cnt, b);
`else
        chk({tag, ".fetch"},  bus_if.perf_fetch_cnt, 16'h0000);
        chk({tag, ".bubble"}, bus_if.perf_bubble_cnt, 16'h0000);
        if (f === 16'hxxxx || b === 16'hxxxx) errors++;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.stall          = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 16'h0000;

        // Reset held for 3 cycles
        step(); step(); step();
        chk("rst.addr",   bus_if.imem_addr, 16'h0000);
        chk("rst.valid",  {15'd0, bus_if.id_valid}, 16'h0000);
        chk("rst.instr",  bus_if.id_instr, 16'h0000);
        chk("rst.pc",     bus_if.id_pc, 16'h0000);
        chk("rst.pc2",    bus_if.id_pc2, 16'h0000);
        chk("rst.fault",  {15'd0, bus_if.fault}, 16'h0000);
        chk_perf("rst", 16'd0, 16'd0);

        // Start-up: one empty edge, then pc 0, 2, 4 captured
        rst = 1'b0;
        step();
        chk("start.valid", {15'd0, bus_if.id_valid}, 16'h0000);
        chk("start.addr",  bus_if.imem_addr, 16'h0000);
        step();
        chk_id("fetch0", 1'b1, 16'h2A51, 16'h0000, 16'h0002);
        step();
        chk_id("fetch2", 1'b1, 16'hC001, 16'h0002, 16'h0004);
        step();
        chk_id("fetch4", 1'b1, 16'hC002, 16'h0004, 16'h0006);

        // Stall three cycles: everything holds
        bus_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_id("stall", 1'b1, 16'hC002, 16'h0004, 16'h0006);
        end
        bus_if.stall = 1'b0;
        step();
        chk_id("fetch6", 1'b1, 16'hC003, 16'h0006, 16'h0008);

        // Redirect while stalled: redirect wins, IF/ID squashed
        bus_if.stall          = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 16'h0010;
        step();
        chk_id("redir", 1'b0, 16'hC003, 16'h0006, 16'h0010);
        bus_if.stall          = 1'b0;
        bus_if.redirect_valid = 1'b0;
        step();
        chk_id("fetch10", 1'b1, 16'hC008, 16'h0010, 16'h0012);
        chk_perf("perf5", 16'd5, 16'd2);

        // Wrap-around at FFFE
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 16'hFFFE;
        step();
        chk("wrap.redir.addr",  bus_if.imem_addr, 16'hFFFE);
        chk("wrap.redir.valid", {15'd0, bus_if.id_valid}, 16'h0000);
        bus_if.redirect_valid = 1'b0;
        step();
        chk_id("fetchFFFE", 1'b1, 16'hC00F, 16'hFFFE, 16'h0000);
        chk("wrap.pc2", bus_if.id_pc2, 16'h0000);
        step();
        chk_id("fetch0w", 1'b1, 16'h2A51, 16'h0000, 16'h0002);

        // Misaligned redirect: fault, freeze, ignore further stall/redirect
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 16'h0013;
        step();
        chk("mis.fault", {15'd0, bus_if.fault}, 16'h0001);
        chk("mis.valid", {15'd0, bus_if.id_valid}, 16'h0000);
        chk("mis.addr",  bus_if.imem_addr, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            bus_if.stall          = i[0];
            bus_if.redirect_valid = ~i[0];
            bus_if.redirect_pc    = 16'h0020;
            step();
            chk("frz.fault", {15'd0, bus_if.fault}, 16'h0001);
            chk("frz.valid", {15'd0, bus_if.id_valid}, 16'h0000);
            chk("frz.addr",  bus_if.imem_addr, 16'h0002);
        end
        chk_perf("perf.fault", 16'd7, 16'd3);

        // Reset wins over a simultaneous redirect and clears the fault
        rst                   = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 16'h0040;
        step();
        chk("rst2.fault", {15'd0, bus_if.fault}, 16'h0000);
        chk("rst2.addr",  bus_if.imem_addr, 16'h0000);
        chk("rst2.valid", {15'd0, bus_if.id_valid}, 16'h0000);
        chk("rst2.pc",    bus_if.id_pc, 16'h0000);
        chk_perf("rst2", 16'd0, 16'd0);
        rst                   = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.stall          = 1'b0;
        step();
        chk("restart.valid", {15'd0, bus_if.id_valid}, 16'h0000);
        step();
        chk_id("restart0", 1'b1, 16'h2A51, 16'h0000, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
